t01_blockid: RTL

//  Inverse of the block generator: identifies the block type code (0..18) whose 4x4 occupancy

---
 rtl/t01_blockid_if.sv | 23 ++
 rtl/t01_blockid.sv | 116 +++++++++++
 2 files changed

// File: rtl/t01_blockid_if.sv
// Handshake and result bundle for the block-type identifier.
// The requester drives start/pattern_in; the identifier returns status and result.
interface t01_blockid_if #(
  parameter int unsigned TYPE_W = 5
) ();
  logic              start;
  logic [15:0]       pattern_in;
  logic              busy;
  logic              done;
  logic [TYPE_W-1:0] block_type;
  logic              found;
  logic              bad_count;

  modport master (
    output start, pattern_in,
    input  busy, done, block_type, found, bad_count
  );

  modport slave (
    input  start, pattern_in,
    output busy, done, block_type, found, bad_count
  );
endinterface

// File: rtl/t01_blockid.sv
// Recovers a block type code from its 4x4 occupancy pattern by a linear table search,
// one entry per clock, with early rejection of patterns that do not have exactly 4 cells.
module t01_blockid #(
  parameter int unsigned NUM_TYPES = 19,
  parameter int unsigned TYPE_W    = 5
) (
  input logic           clk,
  input logic           rst,
  t01_blockid_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

  localparam logic [TYPE_W-1:0] NotFound = {TYPE_W{1'b1}};
  localparam logic [TYPE_W-1:0] LastIdx  = TYPE_W'(NUM_TYPES - 1);

  state_e            state_q, state_d;
  logic [TYPE_W-1:0] idx_q, idx_d;
  logic [15:0]       pat_q, pat_d;
  logic [TYPE_W-1:0] block_type_q, block_type_d;
  logic              found_q, found_d;
  logic              bad_count_q, bad_count_d;

  function automatic logic [15:0] table_entry(input logic [TYPE_W-1:0] idx);
    logic [15:0] p;
    unique case (int'(idx))
      0:       p = 16'h2222;
      1:       p = 16'h0066;
      2:       p = 16'h006C;
      3:       p = 16'h00C6;
      4:       p = 16'h0622;
      5:       p = 16'h0644;
      6:       p = 16'h00E4;
      7:       p = 16'h00F0;
      8:       p = 16'h2640;
      9:       p = 16'h4620;
      10:      p = 16'h0017;
      11:      p = 16'h0446;
      12:      p = 16'h0740;
      13:      p = 16'h0470;
      14:      p = 16'h0226;
      15:      p = 16'h0071;
      16:      p = 16'h4640;
      17:      p = 16'h04E0;
      18:      p = 16'h2620;
      // Zero never matches: pat_q always holds exactly 4 cells during a search
      default: p = 16'h0000;
    endcase
    return p;
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pat_d        = pat_q;
    block_type_d = block_type_q;
    found_d      = found_q;
    bad_count_d  = bad_count_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          pat_d       = bus.pattern_in;
          found_d     = 1'b0;
          bad_count_d = 1'b0;
          idx_d       = '0;
          if ($countones(bus.pattern_in) == 4) begin
            state_d = StSearch;
          end else begin
            state_d      = StDone;
            bad_count_d  = 1'b1;
            block_type_d = NotFound;
          end
        end
      end
      StSearch: begin
        if (pat_q == table_entry(idx_q)) begin
          state_d      = StDone;
          block_type_d = idx_q;
          found_d      = 1'b1;
        end else if (idx_q == LastIdx) begin
          state_d      = StDone;
          block_type_d = NotFound;
        end else begin
          idx_d = idx_q + TYPE_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      pat_q        <= '0;
      block_type_q <= '0;
      found_q      <= 1'b0;
      bad_count_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pat_q        <= pat_d;
      block_type_q <= block_type_d;
      found_q      <= found_d;
      bad_count_q  <= bad_count_d;
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone);
  assign bus.block_type = block_type_q;
  assign bus.found      = found_q;
  assign bus.bad_count  = bad_count_q;

endmodule
